usb_packet_rx_gen: RTL
======================

// Module: usb_packet_rx_gen
// PURPOSE
//  Second-generation USB packet receiver. Consumes the destuffed serial bit stream from the
//  line decoder (LSB first), decodes and validates the PID, checks the CRC5 or CRC16 residual,
//  splits tokens into addr/endp and SOF into frame number, and buffers the data payload (CRC
//  bytes removed) in a byte FIFO with valid/ready. Sits between the line decoder and the
//  protocol engine.
// PARAMETERS
//  MAX_PAYLOAD  1023  max data-payload bytes; longer packets flag err[3]
//  LEN_W        11    width of pkt_len; must hold MAX_PAYLOAD+1
//  FIFO_DEPTH   8     payload FIFO entries; power of 2, >=2
// PORTS
//  clk          in   1      single clock
//  rst          in   1      reset, synchronous, active-high
//  rx_start     in   1      pulse: SYNC seen, new packet begins
//  rx_finish    in   1      pulse: EOP seen, packet ended
//  rx_status    in   1      rx_bit valid this cycle
//  rx_bit       in   1      destuffed data bit, LSB of each byte first
//  pid          out  4      decoded PID nibble (valid when pid_valid)
//  pid_valid    out  1      PID check nibble matched
//  pkt_class    out  2      pid[1:0]: 0 special, 1 token, 2 handshake, 3 data
//  tok_addr     out  7      token device address
//  tok_endp     out  4      token endpoint
//  sof_frame    out  11     SOF frame number
//  pkt_len      out  LEN_W  payload bytes pushed for this packet (data only; else 0)
//  pkt_done     out  1      1-cycle pulse: status outputs final
//  pkt_ok       out  1      packet good (held until next rx_start)
//  err          out  5      {fifo_ovf, too_long, misalign, crc, pid}; held until next rx_start
//  out_data     out  8      FIFO head byte
//  out_valid    out  1      FIFO not empty
//  out_ready    in   1      consumer pops when out_valid & out_ready
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, FIFO empty, CRC5=5'h1F, CRC16=16'hFFFF.
//  - FSM: IDLE -rx_start-> PID -8 bits-> BODY -rx_finish-> CHECK -1 cycle-> IDLE.
//    rx_finish in PID also -> CHECK. rx_start in any state clears per-packet context
//    (pid*, tok*, sof_frame, pkt_len, pkt_ok, err, CRCs, bit/byte counters) -> PID.
//    rx_finish in IDLE ignored. FIFO is never flushed by rx_start.
//  - Priority same cycle: rx_start beats rx_status (bit dropped); rx_status with rx_finish:
//    bit consumed first, then finish. rx_status outside PID/BODY ignored.
//  - PID: 8th bit completes byte b; pid_valid=1 iff b[7:4]==~b[3:0]; pid=b[3:0] next cycle.
//  - CRC: all bits after PID shifted in; CRC5 x^5+x^2+1, CRC16 x^16+x^15+x^2+1, xor bit =
//    crc[MSB]^rx_bit. Pass iff residual CRC5==5'b01100 / CRC16==16'h800D.
//  - Token/SOF: body exactly 16 bits; tok_addr=bits[6:0], tok_endp=bits[10:7],
//    sof_frame=bits[10:0] of body, registered when 16th body bit arrives.
//  - Data: 2-byte holdback register; byte N pushed to FIFO on cycle after byte N+2 completes;
//    final 2 bytes (CRC16) never pushed. pkt_len increments per push, saturates at MAX_PAYLOAD;
//    push beyond MAX_PAYLOAD suppressed and sets too_long.
//  - FIFO: push when full with no pop same cycle -> byte dropped, fifo_ovf set. Push+pop
//    same cycle when full allowed. Empty: out_valid=0, out_data holds last value.
//  - CHECK (cycle after rx_finish): pkt_done=1; misalign if body bits not multiple of 8 or
//    wrong length (token body!=16, handshake body!=0, data body<16); crc per class
//    (handshake/special: no CRC); pid = ~pid_valid. pkt_ok = (class!=0) & (err==0).
//    Status latency: rx_finish cycle T -> pkt_done at T+1.
//  - Consumer discards FIFO bytes of a packet whose pkt_ok=0 (pkt_len bytes).
// CONFIGURATION
//  - PKT_STATS_EN defined: adds outputs stat_good[15:0], stat_bad[15:0]; incremented on
//    pkt_done by pkt_ok / !pkt_ok, saturate at 16'hFFFF, cleared only by rst.
//  - Not defined: ports and counters absent; otherwise identical behaviour.
// TESTING
//  - ACK byte 0xD2 -> pid=4'h2, pid_valid=1, pkt_class=2, pkt_ok=1, err=0, pkt_len=0.
//  - DATA0 C3 00 00 (empty, CRC 0x0000) -> pkt_ok=1, pkt_len=0, no FIFO push.
//  - DATA1 4B 01 02 03 04 + bench CRC16, out_ready=1 -> out 01,02,03,04; pkt_len=4, pkt_ok=1.
//  - OUT token addr 7'h3A endp 4'hA + bench CRC5 -> tok_addr=3A, tok_endp=A, pkt_ok=1;
//    flip one CRC bit -> err=5'b00010, pkt_ok=0.
//  - PID byte 0xC4 -> pid_valid=0, err[0]=1; 10 payload bytes, FIFO_DEPTH=8, out_ready=0
//    -> 8 stored, err[4]=1; rx_start mid-packet -> err/pkt_len cleared, FIFO kept.
//  - PKT_STATS_EN: 3 good + 2 bad packets -> stat_good=3, stat_bad=2; rst -> both 0.

Source files
------------

// File: rtl/usb_packet_rx_gen.sv
`default_nettype none
// ============================================================================
// Module   : usb_packet_rx_gen
// Brief    : USB packet receiver: PID check, CRC5/CRC16 residual check, token and
//            SOF field split, payload byte FIFO. Optional PKT_STATS_EN macro adds
//            good/bad packet counters.
// Revision : 1.0 - initial release
// ============================================================================
module usb_packet_rx_gen #(
    parameter int MAX_PAYLOAD = 1023,
    parameter int LEN_W       = 11,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_start,
    input  logic             rx_finish,
    input  logic             rx_status,
    input  logic             rx_bit,
    output logic [3:0]       pid,
    output logic             pid_valid,
    output logic [1:0]       pkt_class,
    output logic [6:0]       tok_addr,
    output logic [3:0]       tok_endp,
    output logic [10:0]      sof_frame,
    output logic [LEN_W-1:0] pkt_len,
    output logic             pkt_done,
    output logic             pkt_ok,
    output logic [4:0]       err,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PKT_STATS_EN
    ,
    output logic [15:0]      stat_good,
    output logic [15:0]      stat_bad
`endif
);

    localparam int               c_AW        = $clog2(FIFO_DEPTH);
    localparam logic [LEN_W-1:0] c_MAX_LEN   = LEN_W'(MAX_PAYLOAD);
    localparam logic [4:0]       c_CRC5_RES  = 5'b01100;
    localparam logic [15:0]      c_CRC16_RES = 16'h800D;

    typedef enum logic [1:0] {ST_IDLE, ST_PID, ST_BODY, ST_CHECK} state_t;

    typedef struct packed {
        logic [3:0]       pid;
        logic             pid_valid;
        logic [6:0]       tok_addr;
        logic [3:0]       tok_endp;
        logic [10:0]      sof_frame;
        logic [LEN_W-1:0] pkt_len;
        logic             pkt_ok;
        logic [4:0]       err;
        logic [2:0]       bit_cnt;
        logic [1:0]       byte_cnt;
        logic [7:0]       shift;
        logic [7:0]       h0;
        logic [7:0]       h1;
        logic [4:0]       crc5;
        logic [15:0]      crc16;
        logic             push_pend;
        logic [7:0]       push_byte;
    } ctx_t;

    function automatic ctx_t f_ctx_clear();
        ctx_t v;
        v       = '0;
        v.crc5  = 5'h1F;
        v.crc16 = 16'hFFFF;
        return v;
    endfunction

    state_t r_state, w_state_nxt;
    ctx_t   r_ctx, w_ctx;
    logic   r_pkt_done, w_done_nxt;

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [c_AW:0] r_wr_ptr, r_rd_ptr;
    logic [7:0]  r_last;

    logic       w_in_pkt, w_bit_in, w_fb5, w_fb16;
    logic [7:0] w_byte;
    logic       w_empty, w_full, w_pop, w_push_req, w_wr, w_ovf_now, w_long_now;
    logic       w_aligned, w_len_bad, w_crc_bad;

    assign w_in_pkt   = (r_state == ST_PID) || (r_state == ST_BODY);
    assign w_bit_in   = rx_status && w_in_pkt;
    assign w_byte     = {rx_bit, r_ctx.shift[7:1]};
    assign w_fb5      = r_ctx.crc5[4] ^ rx_bit;
    assign w_fb16     = r_ctx.crc16[15] ^ rx_bit;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                        (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop      = !w_empty && out_ready;
    assign w_push_req = r_ctx.push_pend && !rx_start;
    assign w_wr       = w_push_req && (r_ctx.pkt_len != c_MAX_LEN) && (!w_full || w_pop);
    assign w_ovf_now  = w_push_req && (r_ctx.pkt_len != c_MAX_LEN) && w_full && !w_pop;
    assign w_long_now = w_push_req && (r_ctx.pkt_len == c_MAX_LEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (rx_start) begin
            w_state_nxt = ST_PID;
        end else begin
            case (r_state)
                ST_PID: begin
                    if (rx_finish)
                        w_state_nxt = ST_CHECK;
                    else if (w_bit_in && r_ctx.bit_cnt == 3'd7)
                        w_state_nxt = ST_BODY;
                end
                ST_BODY:  if (rx_finish) w_state_nxt = ST_CHECK;
                ST_CHECK: w_state_nxt = ST_IDLE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    // Status is evaluated in the rx_finish cycle using this cycle's updated
    // context so that pkt_done and the final status appear together at T+1.
    always_comb begin
        w_ctx           = r_ctx;
        w_done_nxt      = 1'b0;
        w_aligned       = 1'b1;
        w_len_bad       = 1'b0;
        w_crc_bad       = 1'b0;
        w_ctx.push_pend = 1'b0;
        if (w_wr)       w_ctx.pkt_len = r_ctx.pkt_len + 1'b1;
        if (w_ovf_now)  w_ctx.err[4]  = 1'b1;
        if (w_long_now) w_ctx.err[3]  = 1'b1;
        if (w_bit_in) begin
            w_ctx.shift   = w_byte;
            w_ctx.bit_cnt = r_ctx.bit_cnt + 3'd1;
            if (r_state == ST_PID) begin
                if (r_ctx.bit_cnt == 3'd7) begin
                    w_ctx.pid       = w_byte[3:0];
                    w_ctx.pid_valid = (w_byte[7:4] == ~w_byte[3:0]);
                end
            end else begin
                w_ctx.crc5  = {r_ctx.crc5[3:0], 1'b0} ^ (w_fb5 ? 5'h05 : 5'h00);
                w_ctx.crc16 = {r_ctx.crc16[14:0], 1'b0} ^ (w_fb16 ? 16'h8005 : 16'h0000);
                if (r_ctx.bit_cnt == 3'd7) begin
                    w_ctx.byte_cnt = (r_ctx.byte_cnt == 2'd3) ? 2'd3 : r_ctx.byte_cnt + 2'd1;
                    w_ctx.h0       = r_ctx.h1;
                    w_ctx.h1       = w_byte;
                    if (r_ctx.pid[1:0] == 2'd3 && r_ctx.byte_cnt >= 2'd2) begin
                        w_ctx.push_pend = 1'b1;
                        w_ctx.push_byte = r_ctx.h0;
                    end
                    if (r_ctx.pid[1:0] == 2'd1 && r_ctx.byte_cnt == 2'd1) begin
                        w_ctx.tok_addr  = r_ctx.h1[6:0];
                        w_ctx.tok_endp  = {w_byte[2:0], r_ctx.h1[7]};
                        w_ctx.sof_frame = {w_byte[2:0], r_ctx.h1};
                    end
                end
            end
        end
        if (rx_finish && w_in_pkt) begin
            w_done_nxt = 1'b1;
            if (r_state == ST_BODY) w_aligned = (w_ctx.bit_cnt == 3'd0);
            case (w_ctx.pid[1:0])
                2'd1: begin
                    w_len_bad = (w_ctx.byte_cnt != 2'd2);
                    w_crc_bad = (w_ctx.crc5 != c_CRC5_RES);
                end
                2'd2: w_len_bad = (w_ctx.byte_cnt != 2'd0);
                2'd3: begin
                    w_len_bad = (w_ctx.byte_cnt < 2'd2);
                    w_crc_bad = (w_ctx.crc16 != c_CRC16_RES);
                end
                default: w_len_bad = 1'b0;
            endcase
            w_ctx.err[2:0] = {!w_aligned || w_len_bad, w_crc_bad, !w_ctx.pid_valid};
            w_ctx.pkt_ok   = (w_ctx.pid[1:0] != 2'd0) && (w_ctx.err == 5'd0);
        end
        if (rx_start) begin
            w_ctx      = f_ctx_clear();
            w_done_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctx      <= f_ctx_clear();
            r_pkt_done <= 1'b0;
        end else begin
            r_ctx      <= w_ctx;
            r_pkt_done <= w_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[c_AW-1:0]] <= r_ctx.push_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_last   <= 8'h00;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr[c_AW-1:0]];
            end
        end
    end

`ifdef PKT_STATS_EN
    logic [15:0] r_stat_good, r_stat_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_good <= 16'h0000;
            r_stat_bad  <= 16'h0000;
        end else if (r_pkt_done) begin
            if (r_ctx.pkt_ok && r_stat_good != 16'hFFFF) r_stat_good <= r_stat_good + 16'd1;
            if (!r_ctx.pkt_ok && r_stat_bad != 16'hFFFF) r_stat_bad <= r_stat_bad + 16'd1;
        end
    end

    assign stat_good = r_stat_good;
    assign stat_bad  = r_stat_bad;
`endif

    assign pid       = r_ctx.pid;
    assign pid_valid = r_ctx.pid_valid;
    assign pkt_class = r_ctx.pid[1:0];
    assign tok_addr  = r_ctx.tok_addr;
    assign tok_endp  = r_ctx.tok_endp;
    assign sof_frame = r_ctx.sof_frame;
    assign pkt_len   = r_ctx.pkt_len;
    assign pkt_done  = r_pkt_done;
    assign pkt_ok    = r_ctx.pkt_ok;
    assign err       = r_ctx.err;
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? r_last : r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire
